// File: rtl/d_decode_queue.sv
// Fetch-to-decode queue: compacts masked fetch slots into a circular buffer
// and presents up to WIDTH oldest entries per cycle to the basic decoders.
module d_decode_queue #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            in_pc_i,
  input  logic [WIDTH-1:0]       in_mask_i,
  input  logic [WIDTH*32-1:0]    in_insts_i,
  input  logic [WIDTH-1:0]       in_excp_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH-1:0]       out_mask_o,
  output logic [WIDTH*32-1:0]    out_pc_o,
  output logic [WIDTH*32-1:0]    out_insts_o,
  output logic [WIDTH-1:0]       out_excp_o,
  output logic [CNT_W-1:0]       count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]      ALIGN_MASK = 32'(WIDTH * 4 - 1);
  localparam logic [CNT_W-1:0] WIDTH_C    = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] READY_MAX  = CNT_W'(DEPTH - WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);

  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  logic [CNT_W-1:0] count_q;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic        excp_mem [DEPTH];

  logic             enq;
  logic             deq;
  logic [CNT_W-1:0] n_in;
  logic [CNT_W-1:0] n_out;
  logic [AW-1:0]    slot_pos [WIDTH];
  logic [31:0]      slot_pc  [WIDTH];
  logic [AW-1:0]    rd_idx   [WIDTH];

  assign in_ready_o  = (count_q <= READY_MAX);
  assign out_valid_o = (count_q != '0);
  assign count_o     = count_q;

  assign enq = in_valid_i && in_ready_o && !flush_i;
  assign deq = out_valid_o && out_ready_i && !flush_i;

  // Each set mask bit lands at tail plus the number of set bits below it.
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      slot_pos[i] = AW'(acc);
      slot_pc[i]  = (in_pc_i & ~ALIGN_MASK) | 32'(i * 4);
      acc         = acc + CNT_W'(in_mask_i[i]);
    end
    n_in = acc;
  end

  assign n_out = (count_q < WIDTH_C) ? count_q : WIDTH_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + AW'(n_in);
      if (deq) head_q <= head_q + AW'(n_out);
      count_q <= count_q + (enq ? n_in : '0) - (deq ? n_out : '0);
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_mask_i[i]) begin
          pc_mem[tail_q + slot_pos[i]]   <= slot_pc[i];
          inst_mem[tail_q + slot_pos[i]] <= in_insts_i[32*i +: 32];
          excp_mem[tail_q + slot_pos[i]] <= in_excp_i[i];
        end
      end
    end
  end

  always_comb begin
    out_mask_o  = '0;
    out_pc_o    = '0;
    out_insts_o = '0;
    out_excp_o  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rd_idx[i] = head_q + AW'(i);
      if (CNT_W'(i) < count_q) begin
        out_mask_o[i]           = 1'b1;
        out_pc_o[32*i +: 32]    = pc_mem[rd_idx[i]];
        out_insts_o[32*i +: 32] = inst_mem[rd_idx[i]];
        out_excp_o[i]           = excp_mem[rd_idx[i]];
      end
    end
  end

  a_pc_align: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid_i |-> ((in_pc_i & ALIGN_MASK) == 32'd0));

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= DEPTH_C);

endmodule

// File: tb/tb_d_decode_queue.sv
// Directed bench for d_decode_queue (WIDTH=2, DEPTH=8): vector table plus
// hand sequences for streaming, flush and asynchronous reset.
module tb_d_decode_queue;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_pc_i;
  logic [1:0]  in_mask_i;
  logic [63:0] in_insts_i;
  logic [1:0]  in_excp_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [1:0]  out_mask_o;
  logic [63:0] out_pc_o;
  logic [63:0] out_insts_o;
  logic [1:0]  out_excp_o;
  logic [3:0]  count_o;

  int checks = 0;
  int errors = 0;

  d_decode_queue #(.WIDTH(2), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i),
    .in_mask_i(in_mask_i), .in_insts_i(in_insts_i), .in_excp_i(in_excp_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_mask_o(out_mask_o), .out_pc_o(out_pc_o), .out_insts_o(out_insts_o),
    .out_excp_o(out_excp_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [31:0] pc;
    logic [1:0]  mask;
    logic [63:0] insts;
    logic [1:0]  excp;
    logic        out_ready;
    logic [3:0]  e_count;
    logic        e_ready;
    logic        e_valid;
    logic [1:0]  e_mask;
    logic [31:0] e_pc0;
    logic [31:0] e_pc1;
    logic [31:0] e_inst0;
    logic [31:0] e_inst1;
    logic [1:0]  e_excp;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [1:0] m,
                              input logic [63:0] ins, input logic [1:0] ex, input logic rdy,
                              input logic [3:0] ec, input logic er, input logic ev,
                              input logic [1:0] em, input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] ee);
    vec_t r;
    r.in_valid = v; r.pc = pc; r.mask = m; r.insts = ins; r.excp = ex; r.out_ready = rdy;
    r.e_count = ec; r.e_ready = er; r.e_valid = ev; r.e_mask = em;
    r.e_pc0 = p0; r.e_pc1 = p1; r.e_inst0 = i0; r.e_inst1 = i1; r.e_excp = ee;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic fl, input logic v, input logic [31:0] pc, input logic [1:0] m,
                      input logic [63:0] ins, input logic [1:0] ex, input logic rdy);
    flush_i = fl; in_valid_i = v; in_pc_i = pc; in_mask_i = m;
    in_insts_i = ins; in_excp_i = ex; out_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pk(input logic [31:0] s1, input logic [31:0] s0);
    return {s1, s0};
  endfunction

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] nxt_pc;

    flush_i = 0; in_valid_i = 0; in_pc_i = 0; in_mask_i = 0;
    in_insts_i = 0; in_excp_i = 0; out_ready_i = 0;
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    chk("reset_count", 32'(count_o), 32'd0);
    chk("reset_ready", 32'(in_ready_o), 32'd1);
    chk("reset_valid", 32'(out_valid_o), 32'd0);
    chk("reset_mask", 32'(out_mask_o), 32'd0);

    vecs[0]  = mk(1, 32'h1C000000, 2'b11, pk(32'hBBBB0000, 32'hAAAA0000), 2'b01, 0,
                  4'd2, 1, 1, 2'b11, 32'h1C000000, 32'h1C000004, 32'hAAAA0000, 32'hBBBB0000, 2'b01);
    vecs[1]  = mk(1, 32'h1C000008, 2'b10, pk(32'hCCCC0000, 32'hDEAD0000), 2'b10, 1,
                  4'd1, 1, 1, 2'b01, 32'h1C00000C, 32'h0, 32'hCCCC0000, 32'h0, 2'b01);
    vecs[2]  = mk(0, 32'h0, 2'b00, 64'h0, 2'b00, 1,
                  4'd0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    vecs[3]  = mk(1, 32'h100, 2'b11, pk(32'h1001, 32'h1000), 2'b00, 0,
                  4'd2, 1, 1, 2'b11, 32'h100, 32'h104, 32'h1000, 32'h1001, 2'b00);
    vecs[4]  = mk(1, 32'h108, 2'b11, pk(32'h1003, 32'h1002), 2'b00, 0,
                  4'd4, 1, 1, 2'b11, 32'h100, 32'h104, 32'h1000, 32'h1001, 2'b00);
    vecs[5]  = mk(1, 32'h110, 2'b11, pk(32'h1005, 32'h1004), 2'b00, 0,
                  4'd6, 1, 1, 2'b11, 32'h100, 32'h104, 32'h1000, 32'h1001, 2'b00);
    vecs[6]  = mk(1, 32'h118, 2'b11, pk(32'h1007, 32'h1006), 2'b00, 0,
                  4'd8, 0, 1, 2'b11, 32'h100, 32'h104, 32'h1000, 32'h1001, 2'b00);
    vecs[7]  = mk(1, 32'h200, 2'b11, pk(32'h9999, 32'h9998), 2'b00, 0,
                  4'd8, 0, 1, 2'b11, 32'h100, 32'h104, 32'h1000, 32'h1001, 2'b00);
    vecs[8]  = mk(0, 32'h0, 2'b00, 64'h0, 2'b00, 1,
                  4'd6, 1, 1, 2'b11, 32'h108, 32'h10C, 32'h1002, 32'h1003, 2'b00);
    vecs[9]  = mk(0, 32'h0, 2'b00, 64'h0, 2'b00, 1,
                  4'd4, 1, 1, 2'b11, 32'h110, 32'h114, 32'h1004, 32'h1005, 2'b00);
    vecs[10] = mk(0, 32'h0, 2'b00, 64'h0, 2'b00, 1,
                  4'd2, 1, 1, 2'b11, 32'h118, 32'h11C, 32'h1006, 32'h1007, 2'b00);
    vecs[11] = mk(0, 32'h0, 2'b00, 64'h0, 2'b00, 1,
                  4'd0, 1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);

    for (int i = 0; i < 12; i++) begin
      step(0, vecs[i].in_valid, vecs[i].pc, vecs[i].mask, vecs[i].insts,
           vecs[i].excp, vecs[i].out_ready);
      chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vecs[i].e_count));
      chk($sformatf("v%0d_ready", i), 32'(in_ready_o), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_valid", i), 32'(out_valid_o), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_mask", i), 32'(out_mask_o), 32'(vecs[i].e_mask));
      chk($sformatf("v%0d_pc0", i), out_pc_o[31:0], vecs[i].e_pc0);
      chk($sformatf("v%0d_pc1", i), out_pc_o[63:32], vecs[i].e_pc1);
      chk($sformatf("v%0d_inst0", i), out_insts_o[31:0], vecs[i].e_inst0);
      chk($sformatf("v%0d_inst1", i), out_insts_o[63:32], vecs[i].e_inst1);
      chk($sformatf("v%0d_excp", i), 32'(out_excp_o), 32'(vecs[i].e_excp));
    end

    // Steady stream: prime to 6 entries, then enqueue 2 / dequeue 2 for 20 cycles.
    for (int k = 0; k < 3; k++) begin
      nxt_pc = 32'h400 + 32'(k * 8);
      step(0, 1, nxt_pc, 2'b11, pk(nxt_pc + 32'h50000004, nxt_pc + 32'h50000000), 2'b00, 0);
    end
    chk("stream_prime_count", 32'(count_o), 32'd6);
    exp_pc = 32'h400;
    chk("stream_prime_pc0", out_pc_o[31:0], exp_pc);
    for (int k = 0; k < 20; k++) begin
      nxt_pc = 32'h418 + 32'(k * 8);
      step(0, 1, nxt_pc, 2'b11, pk(nxt_pc + 32'h50000004, nxt_pc + 32'h50000000), 2'b00, 1);
      exp_pc = exp_pc + 32'd8;
      chk($sformatf("stream%0d_count", k), 32'(count_o), 32'd6);
      chk($sformatf("stream%0d_pc0", k), out_pc_o[31:0], exp_pc);
      chk($sformatf("stream%0d_pc1", k), out_pc_o[63:32], exp_pc + 32'd4);
      chk($sformatf("stream%0d_inst0", k), out_insts_o[31:0], exp_pc + 32'h50000000);
    end

    // Bring occupancy to 5, then flush with live handshakes on both sides.
    nxt_pc = 32'h418 + 32'(20 * 8);
    step(0, 1, nxt_pc, 2'b01, pk(32'h0, nxt_pc + 32'h50000000), 2'b00, 1);
    chk("pre_flush_count", 32'(count_o), 32'd5);
    chk("pre_flush_pc0", out_pc_o[31:0], exp_pc + 32'd8);
    step(1, 1, 32'h700, 2'b11, pk(32'h77770004, 32'h77770000), 2'b11, 1);
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    chk("flush_mask", 32'(out_mask_o), 32'd0);
    chk("flush_ready", 32'(in_ready_o), 32'd1);
    chk("flush_pc", out_pc_o[31:0], 32'd0);
    step(0, 0, 32'h0, 2'b00, 64'h0, 2'b00, 1);
    chk("post_flush_count", 32'(count_o), 32'd0);
    step(0, 1, 32'h600, 2'b11, pk(32'h66660004, 32'h66660000), 2'b00, 0);
    chk("post_flush_enq_count", 32'(count_o), 32'd2);
    chk("post_flush_enq_pc0", out_pc_o[31:0], 32'h600);
    chk("post_flush_enq_inst1", out_insts_o[63:32], 32'h66660004);

    // Asynchronous reset at occupancy 3, dropped away from any clock edge.
    step(0, 1, 32'h608, 2'b01, pk(32'h0, 32'h66680000), 2'b00, 0);
    chk("pre_reset_count", 32'(count_o), 32'd3);
    in_valid_i = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_count", 32'(count_o), 32'd0);
    chk("async_reset_valid", 32'(out_valid_o), 32'd0);
    chk("async_reset_mask", 32'(out_mask_o), 32'd0);
    chk("async_reset_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(0, 1, 32'h800, 2'b11, pk(32'h88880004, 32'h88880000), 2'b00, 0);
    chk("post_reset_count", 32'(count_o), 32'd2);
    chk("post_reset_pc0", out_pc_o[31:0], 32'h800);
    chk("post_reset_pc1", out_pc_o[63:32], 32'h804);
    chk("post_reset_inst0", out_insts_o[31:0], 32'h88880000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
